// File: rtl/vram_fill_pkg.sv
// Shared LCD definitions: panel geometry, bus widths, fill FSM encoding and a
// constant-coefficient shift/add multiplier for row-base computation.
package vram_fill_pkg;

    localparam int HPXL_D = 800;
    localparam int VPXL_D = 480;
    localparam int ABW    = 19;
    localparam int HBW    = 10;
    localparam int VBW    = 9;
    localparam int CBW    = 24;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } fill_state_e;

    // y * k using only shifts and adds over the set bits of the constant k
    function automatic logic [ABW-1:0] mul_const(input logic [VBW-1:0] y, input int k);
        logic [ABW-1:0] acc;
        acc = '0;
        for (int i = 0; i < ABW; i++)
            if (k[i]) acc = acc + (ABW'(y) << i);
        return acc;
    endfunction

endpackage

// File: rtl/vram_fill_if.sv
// Request / VRAM write-port bundle of the rectangle filler.
interface vram_fill_if;
    import vram_fill_pkg::*;

    logic            iSTART;
    logic [HBW-1:0]  iX0;
    logic [VBW-1:0]  iY0;
    logic [HBW-1:0]  iW;
    logic [VBW-1:0]  iH;
    logic [CBW-1:0]  iCOLOR;
    logic [ABW-1:0]  oWADDR;
    logic [CBW-1:0]  oWDATA;
    logic            oWE;
    logic            iWREADY;
    logic            oBUSY;
    logic            oDONE;

    modport slave (
        input  iSTART, iX0, iY0, iW, iH, iCOLOR, iWREADY,
        output oWADDR, oWDATA, oWE, oBUSY, oDONE
    );

    modport master (
        output iSTART, iX0, iY0, iW, iH, iCOLOR, iWREADY,
        input  oWADDR, oWDATA, oWE, oBUSY, oDONE
    );

endinterface

// File: rtl/vram_fill_addr.sv
// Raster address walker: column/row counters with a row-base accumulator so
// the row wrap costs one add of HPXL instead of a multiply.
module vram_fill_addr
    import vram_fill_pkg::*;
#(
    parameter int HPXL = HPXL_D
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic           i_load,
    input  logic           i_adv,
    input  logic [ABW-1:0] i_base,
    input  logic [HBW-1:0] i_w,
    input  logic [VBW-1:0] i_h,
    output logic [ABW-1:0] o_addr,
    output logic           o_last
);

    logic [HBW-1:0] r_col;
    logic [VBW-1:0] r_row;
    logic [HBW-1:0] r_w;
    logic [VBW-1:0] r_h;
    logic [ABW-1:0] r_rbase;
    logic [ABW-1:0] r_addr;
    logic           w_col_end;
    logic [ABW-1:0] w_next_rbase;

    assign w_col_end    = (r_col == r_w - HBW'(1));
    assign w_next_rbase = r_rbase + ABW'(HPXL);
    assign o_last       = w_col_end && (r_row == r_h - VBW'(1));
    assign o_addr       = r_addr;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_col   <= '0;
            r_row   <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_rbase <= '0;
            r_addr  <= '0;
        end else if (i_load) begin
            r_col   <= '0;
            r_row   <= '0;
            r_w     <= i_w;
            r_h     <= i_h;
            r_rbase <= i_base;
            r_addr  <= i_base;
        end else if (i_adv) begin
            if (w_col_end) begin
                r_col   <= '0;
                r_row   <= r_row + VBW'(1);
                r_rbase <= w_next_rbase;
                r_addr  <= w_next_rbase;
            end else begin
                r_col   <= r_col + HBW'(1);
                r_addr  <= r_addr + ABW'(1);
            end
        end
    end

endmodule

// File: rtl/vram_fill.sv
// Rectangle fill engine: latches a request, clips it to the panel in SETUP,
// then streams one colour write per granted cycle in raster order.
module vram_fill
    import vram_fill_pkg::*;
#(
    parameter int HPXL = HPXL_D,
    parameter int VPXL = VPXL_D
) (
    input  logic        clk,
    input  logic        rst_,
    vram_fill_if.slave  bus
);

    fill_state_e    r_state;
    fill_state_e    w_next;
    logic [HBW-1:0] r_x0;
    logic [VBW-1:0] r_y0;
    logic [HBW-1:0] r_w;
    logic [VBW-1:0] r_h;
    logic [CBW-1:0] r_color;

    logic [HBW-1:0] w_room_x;
    logic [VBW-1:0] w_room_y;
    logic [HBW-1:0] w_eff_w;
    logic [VBW-1:0] w_eff_h;
    logic           w_empty;
    logic [ABW-1:0] w_base;
    logic [ABW-1:0] w_addr;
    logic           w_last;
    logic           w_acc;

    // Clip against the panel edge; an origin past the edge leaves no room at all
    assign w_room_x = (r_x0 < HBW'(HPXL)) ? HBW'(HPXL) - r_x0 : '0;
    assign w_room_y = (r_y0 < VBW'(VPXL)) ? VBW'(VPXL) - r_y0 : '0;
    assign w_eff_w  = (r_w < w_room_x) ? r_w : w_room_x;
    assign w_eff_h  = (r_h < w_room_y) ? r_h : w_room_y;
    assign w_empty  = (w_eff_w == '0) || (w_eff_h == '0);
    assign w_base   = mul_const(r_y0, HPXL) + ABW'(r_x0);

    assign w_acc    = (r_state == S_RUN) && bus.iWREADY;

    vram_fill_addr #(.HPXL(HPXL)) u_addr (
        .clk    (clk),
        .rst_   (rst_),
        .i_load (r_state == S_SETUP),
        .i_adv  (w_acc),
        .i_base (w_base),
        .i_w    (w_eff_w),
        .i_h    (w_eff_h),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
        end else if (r_state == S_IDLE && bus.iSTART) begin
            r_x0    <= bus.iX0;
            r_y0    <= bus.iY0;
            r_w     <= bus.iW;
            r_h     <= bus.iH;
            r_color <= bus.iCOLOR;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.iSTART) w_next = S_SETUP;
            S_SETUP: w_next = w_empty ? S_DONE : S_RUN;
            S_RUN:   if (w_acc && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.oWE    = (r_state == S_RUN);
    assign bus.oBUSY  = (r_state == S_SETUP) || (r_state == S_RUN);
    assign bus.oDONE  = (r_state == S_DONE);
    assign bus.oWADDR = w_addr;
    assign bus.oWDATA = r_color;

endmodule

// File: tb/tb_vram_fill.sv
// Self-checking bench for vram_fill: directed corner fills plus randomized
// rectangles against a clipped-rectangle raster model.
module tb_vram_fill;
    import vram_fill_pkg::*;

    localparam int HP = 800;
    localparam int VP = 480;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    vram_fill_if vif();

    vram_fill #(.HPXL(HP), .VPXL(VP)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (vif)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected write list: every pixel of the rectangle that lies on the panel
    task automatic build_exp(input int x0, input int y0, input int w, input int h);
        exp_q.delete();
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                if (x < HP && y < VP) exp_q.push_back(y * HP + x);
    endtask

    // rmode: 0 ready always, 1 random ready, 2 fixed ready pattern
    task automatic run_fill(input int x0, input int y0, input int w, input int h,
                            input logic [23:0] col, input int rmode, input bit restart_req);
        int k, nwr, nexp, bound, nwe, e;
        bit done_seen, prev_stall, restart, rdy;
        logic [18:0] prev_addr;
        logic we, busy, done;
        logic [18:0] addr;
        logic [23:0] data;
        build_exp(x0, y0, w, h);
        nexp = exp_q.size();
        restart = restart_req && (nexp >= 3);
        @(negedge clk);
        vif.iSTART  = 1'b1;
        vif.iX0     = 10'(x0);
        vif.iY0     = 9'(y0);
        vif.iW      = 10'(w);
        vif.iH      = 9'(h);
        vif.iCOLOR  = col;
        vif.iWREADY = 1'b0;
        k = 0; nwr = 0; nwe = 0; done_seen = 0; prev_stall = 0; prev_addr = '0;
        bound = ((rmode == 0) ? nexp : 8 * nexp) + 20;
        while (!done_seen && k < bound) begin
            @(negedge clk);
            k++;
            we = vif.oWE; busy = vif.oBUSY; done = vif.oDONE;
            addr = vif.oWADDR; data = vif.oWDATA;
            if (k == 1) begin
                chk("setup_busy", 32'(busy), 1);
                chk("setup_we", 32'(we), 0);
            end
            if (k == 2 && rmode == 0 && nexp > 0) chk("first_we_latency", 32'(we), 1);
            if (prev_stall) begin
                chk("stall_hold_addr", 32'(addr), 32'(prev_addr));
                chk("stall_hold_we", 32'(we), 1);
            end
            if (done) begin
                done_seen = 1;
                chk("write_count", nwr, nexp);
                chk("done_busy", 32'(busy), 0);
                chk("done_we", 32'(we), 0);
                if (rmode == 0) chk("done_cycle", k, nexp + 2);
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (nwe < 5) ? pat[nwe] : 1'b1;
            endcase
            vif.iWREADY = rdy;
            // Inputs wander after the start edge; a second start mid-fill must be ignored
            vif.iSTART = restart && (k == 3);
            vif.iX0    = 10'($urandom);
            vif.iY0    = 9'($urandom);
            vif.iW     = 10'($urandom);
            vif.iH     = 9'($urandom);
            vif.iCOLOR = ~col;
            if (we) begin
                nwe++;
                if (rdy) begin
                    if (exp_q.size() == 0) chk("extra_write", nwr + 1, nexp);
                    else begin
                        e = exp_q.pop_front();
                        chk("waddr", 32'(addr), e);
                        chk("wdata", 32'(data), 32'(col));
                    end
                    nwr++;
                end
                prev_stall = !rdy;
                prev_addr  = addr;
            end else prev_stall = 0;
        end
        if (!done_seen) chk("done_timeout", 0, 1);
        vif.iSTART = 1'b0;
        vif.iWREADY = 1'b0;
        @(negedge clk);
        chk("done_single", 32'(vif.oDONE), 0);
        chk("idle_busy", 32'(vif.oBUSY), 0);
        chk("idle_we", 32'(vif.oWE), 0);
    endtask

    initial begin
        int x0, y0, w, h;
        vif.iSTART = 0; vif.iX0 = '0; vif.iY0 = '0; vif.iW = '0; vif.iH = '0;
        vif.iCOLOR = '0; vif.iWREADY = 0;
        rst_ = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(vif.oWE), 0);
        chk("rst_busy", 32'(vif.oBUSY), 0);
        chk("rst_done", 32'(vif.oDONE), 0);
        chk("rst_waddr", 32'(vif.oWADDR), 0);
        chk("rst_wdata", 32'(vif.oWDATA), 0);
        rst_ = 1'b1;

        run_fill(0, 0, 4, 2, 24'hFF0000, 0, 0);
        run_fill(798, 479, 10, 5, 24'h00FF00, 0, 0);
        run_fill(5, 5, 0, 3, 24'h123456, 0, 0);
        run_fill(800, 10, 5, 5, 24'h654321, 0, 0);
        run_fill(10, 20, 4, 0, 24'hABCDEF, 0, 0);
        run_fill(10, 1, 3, 1, 24'h0000FF, 2, 0);
        run_fill(20, 30, 6, 3, 24'hC0FFEE, 0, 1);
        run_fill(50, 60, 7, 4, 24'h777777, 1, 1);

        // Reset in the middle of a large fill aborts it cleanly
        @(negedge clk);
        vif.iSTART = 1; vif.iX0 = 10'd100; vif.iY0 = 9'd100; vif.iW = 10'd100;
        vif.iH = 9'd100; vif.iCOLOR = 24'h112233; vif.iWREADY = 1;
        @(negedge clk);
        vif.iSTART = 0;
        repeat (30) @(negedge clk);
        chk("pre_abort_we", 32'(vif.oWE), 1);
        rst_ = 1'b0;
        @(negedge clk);
        chk("abort_we", 32'(vif.oWE), 0);
        chk("abort_busy", 32'(vif.oBUSY), 0);
        chk("abort_done", 32'(vif.oDONE), 0);
        chk("abort_waddr", 32'(vif.oWADDR), 0);
        rst_ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(vif.oDONE), 0);
        end
        vif.iWREADY = 0;
        run_fill(3, 2, 5, 3, 24'h0A0B0C, 0, 0);

        for (int n = 0; n < 24; n++) begin
            x0 = ($urandom_range(0, 3) == 0) ? $urandom_range(780, 820) : $urandom_range(0, 800);
            y0 = ($urandom_range(0, 3) == 0) ? $urandom_range(470, 490) : $urandom_range(0, 480);
            w  = $urandom_range(0, 40);
            h  = $urandom_range(0, 6);
            run_fill(x0, y0, w, h, 24'($urandom), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
